char_text_buffer: RTL and testbench

Display-side responder for the text overlay's character interface. It holds a 16x16 grid of 8-bit character codes and returns the glyph row `char_pixels` for each `char_xy`/`char_line` request from the overlay stage. It also exposes a valid/ready command port for writing text, moving the cursor, issuing newlines and clearing the screen. It sits between the text source (control logic or UART front end) and the character-overlay stage of the VGA pipeline.

---
 rtl/char_text_pkg.sv | 39 +++
 rtl/font_rom.sv | 105 ++++++++++
 rtl/char_text_buffer.sv | 158 +++++++++++++++
 tb/tb_char_text_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/char_text_pkg.sv
// Shared definitions for the character text buffer: command encodings,
// grid geometry, FSM state type and cursor-motion helpers.
package char_text_pkg;

  localparam logic [1:0] CMD_PUT     = 2'b00;
  localparam logic [1:0] CMD_SETCUR  = 2'b01;
  localparam logic [1:0] CMD_CLEAR   = 2'b10;
  localparam logic [1:0] CMD_NEWLINE = 2'b11;

  localparam int GRID_COLS = 16;
  localparam int GRID_ROWS = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Cursor format is {col[3:0], row[3:0]}; rows wrap at the bottom of the grid.
  function automatic logic [7:0] cursor_newline(input logic [7:0] cur);
    logic [3:0] row;
    row = cur[3:0];
    if (row == 4'(GRID_ROWS - 1)) begin
      return 8'h00;
    end else begin
      return {4'h0, row + 4'h1};
    end
  endfunction

  function automatic logic [7:0] cursor_advance(input logic [7:0] cur);
    logic [3:0] col;
    col = cur[7:4];
    if (col == 4'(GRID_COLS - 1)) begin
      return cursor_newline(cur);
    end else begin
      return {col + 4'h1, cur[3:0]};
    end
  endfunction

endpackage

// File: rtl/font_rom.sv
// 2048x8 synchronous glyph ROM, address {code[6:0], line[3:0]}, registered output
// with polarity inversion and a force-all-ones override for the cursor underline.
module font_rom (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] addr,
  input  logic        invert,
  input  logic        force_ones,
  output logic [7:0]  data
);

  // 5x7 glyphs, row 0 in bits [34:30]; unknown codes render as a hollow box.
  function automatic logic [34:0] glyph5x7(input logic [6:0] c);
    case (c)
      7'h20: return 35'b00000_00000_00000_00000_00000_00000_00000;
      7'h21: return 35'b00100_00100_00100_00100_00100_00000_00100;
      7'h2D: return 35'b00000_00000_00000_11111_00000_00000_00000;
      7'h2E: return 35'b00000_00000_00000_00000_00000_01100_01100;
      7'h30: return 35'b01110_10001_10011_10101_11001_10001_01110;
      7'h31: return 35'b00100_01100_00100_00100_00100_00100_01110;
      7'h32: return 35'b01110_10001_00001_00010_00100_01000_11111;
      7'h33: return 35'b11110_00001_00001_01110_00001_00001_11110;
      7'h34: return 35'b00010_00110_01010_10010_11111_00010_00010;
      7'h35: return 35'b11111_10000_11110_00001_00001_10001_01110;
      7'h36: return 35'b00110_01000_10000_11110_10001_10001_01110;
      7'h37: return 35'b11111_00001_00010_00100_01000_01000_01000;
      7'h38: return 35'b01110_10001_10001_01110_10001_10001_01110;
      7'h39: return 35'b01110_10001_10001_01111_00001_00010_01100;
      7'h3A: return 35'b00000_01100_01100_00000_01100_01100_00000;
      7'h41: return 35'b01110_10001_10001_11111_10001_10001_10001;
      7'h42: return 35'b11110_10001_10001_11110_10001_10001_11110;
      7'h43: return 35'b01110_10001_10000_10000_10000_10001_01110;
      7'h44: return 35'b11110_10001_10001_10001_10001_10001_11110;
      7'h45: return 35'b11111_10000_10000_11110_10000_10000_11111;
      7'h46: return 35'b11111_10000_10000_11110_10000_10000_10000;
      7'h47: return 35'b01110_10001_10000_10111_10001_10001_01111;
      7'h48: return 35'b10001_10001_10001_11111_10001_10001_10001;
      7'h49: return 35'b01110_00100_00100_00100_00100_00100_01110;
      7'h4A: return 35'b00111_00010_00010_00010_00010_10010_01100;
      7'h4B: return 35'b10001_10010_10100_11000_10100_10010_10001;
      7'h4C: return 35'b10000_10000_10000_10000_10000_10000_11111;
      7'h4D: return 35'b10001_11011_10101_10101_10001_10001_10001;
      7'h4E: return 35'b10001_10001_11001_10101_10011_10001_10001;
      7'h4F: return 35'b01110_10001_10001_10001_10001_10001_01110;
      7'h50: return 35'b11110_10001_10001_11110_10000_10000_10000;
      7'h51: return 35'b01110_10001_10001_10001_10101_10010_01101;
      7'h52: return 35'b11110_10001_10001_11110_10100_10010_10001;
      7'h53: return 35'b01111_10000_10000_01110_00001_00001_11110;
      7'h54: return 35'b11111_00100_00100_00100_00100_00100_00100;
      7'h55: return 35'b10001_10001_10001_10001_10001_10001_01110;
      7'h56: return 35'b10001_10001_10001_10001_10001_01010_00100;
      7'h57: return 35'b10001_10001_10001_10101_10101_10101_01010;
      7'h58: return 35'b10001_10001_01010_00100_01010_10001_10001;
      7'h59: return 35'b10001_10001_01010_00100_00100_00100_00100;
      7'h5A: return 35'b11111_00001_00010_00100_01000_10000_11111;
      default: return 35'b11111_10001_10001_10001_10001_10001_11111;
    endcase
  endfunction

  logic [6:0]  code_s;
  logic [3:0]  line_s;
  logic [6:0]  folded_s;
  logic [34:0] glyph_s;
  logic [2:0]  row_idx_s;
  logic [4:0]  row_bits_s;
  logic [7:0]  pix_s;
  logic [7:0]  data_r;

  assign code_s = addr[10:4];
  assign line_s = addr[3:0];
  assign data   = data_r;

  // Glyph lookup: lines 0-1 are blank, each glyph row spans two lines from line 2.
  always_comb begin
    row_idx_s  = 3'd0;
    row_bits_s = 5'd0;
    if (code_s >= 7'h61 && code_s <= 7'h7A) begin
      folded_s = code_s - 7'h20;
    end else begin
      folded_s = code_s;
    end
    glyph_s = glyph5x7(folded_s);
    if (line_s >= 4'd2) begin
      row_idx_s  = 3'((line_s - 4'd2) >> 1);
      row_bits_s = 5'(glyph_s >> (6'd30 - 6'd5 * {3'b000, row_idx_s}));
    end else begin
      row_bits_s = 5'd0;
    end
    pix_s = {1'b0, row_bits_s, 2'b00};
  end

  // Registered ROM output with override and inversion.
  always_ff @(posedge pclk) begin
    if (rst) begin
      data_r <= 8'h00;
    end else if (force_ones) begin
      data_r <= 8'hFF;
    end else if (invert) begin
      data_r <= ~pix_s;
    end else begin
      data_r <= pix_s;
    end
  end

endmodule

// File: rtl/char_text_buffer.sv
// 16x16 character text buffer with command port and two-stage glyph readout.
// Optional blinking underline cursor enabled by macro CHAR_TEXT_CURSOR_EN.
module char_text_buffer
  import char_text_pkg::*;
#(
  parameter logic [7:0]  CLEAR_CHAR   = 8'h20,
  parameter logic [31:0] BLINK_CYCLES = 32'd32_500_000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  input  logic [3:0] char_line,
  output logic [7:0] char_pixels,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_cmd,
  input  logic [7:0] wr_code,
  output logic [7:0] cursor,
  output logic       busy
);

  logic [7:0] mem_r [256];

  state_t     state_r, state_nxt_s;
  logic [7:0] clr_addr_r, clr_nxt_s;
  logic [7:0] cursor_r, cursor_nxt_s;
  logic       wr_ready_r;
  logic       busy_r;
  logic       we_s;
  logic [7:0] waddr_s;
  logic [7:0] wdata_s;

  logic [7:0] code_r;
  logic [3:0] line_r;
  logic       force_s;

  assign wr_ready = wr_ready_r;
  assign busy     = busy_r;
  assign cursor   = cursor_r;

  // Command decode and clear sequencing.
  always_comb begin
    state_nxt_s  = state_r;
    clr_nxt_s    = clr_addr_r;
    cursor_nxt_s = cursor_r;
    we_s         = 1'b0;
    waddr_s      = cursor_r;
    wdata_s      = wr_code;
    case (state_r)
      IDLE: begin
        if (wr_valid && wr_ready_r) begin
          case (wr_cmd)
            CMD_PUT: begin
              we_s         = 1'b1;
              cursor_nxt_s = cursor_advance(cursor_r);
            end
            CMD_SETCUR:  cursor_nxt_s = wr_code;
            CMD_CLEAR: begin
              state_nxt_s = CLEAR;
              clr_nxt_s   = 8'h00;
            end
            CMD_NEWLINE: cursor_nxt_s = cursor_newline(cursor_r);
            default:     cursor_nxt_s = cursor_r;
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        we_s      = 1'b1;
        waddr_s   = clr_addr_r;
        wdata_s   = CLEAR_CHAR;
        clr_nxt_s = clr_addr_r + 8'd1;
        if (clr_addr_r == 8'hFF) begin
          state_nxt_s  = IDLE;
          cursor_nxt_s = 8'h00;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control registers; reset parks the FSM at the start of a full clear.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r    <= CLEAR;
      clr_addr_r <= 8'h00;
      cursor_r   <= 8'h00;
      wr_ready_r <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      clr_addr_r <= clr_nxt_s;
      cursor_r   <= cursor_nxt_s;
      wr_ready_r <= (state_nxt_s == IDLE);
      busy_r     <= (state_nxt_s == CLEAR);
    end
  end

  // Code RAM write port; reset never writes so contents come from the clear.
  always_ff @(posedge pclk) begin
    if (!rst && we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // Display stage 1: read-first RAM read with the glyph line delayed alongside.
  always_ff @(posedge pclk) begin
    code_r <= mem_r[char_xy];
    line_r <= char_line;
  end

`ifdef CHAR_TEXT_CURSOR_EN
  logic [31:0] blink_cnt_r;
  logic        blink_on_r;
  logic        cur_hit_r;

  // Blink half-period timer.
  always_ff @(posedge pclk) begin
    if (rst) begin
      blink_cnt_r <= 32'd0;
      blink_on_r  <= 1'b1;
    end else if (blink_cnt_r == BLINK_CYCLES - 32'd1) begin
      blink_cnt_r <= 32'd0;
      blink_on_r  <= ~blink_on_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 32'd1;
    end
  end

  // Cursor hit travels with stage 1 so the underline keeps the 2-cycle latency.
  always_ff @(posedge pclk) begin
    if (rst) begin
      cur_hit_r <= 1'b0;
    end else begin
      cur_hit_r <= blink_on_r && (char_xy == cursor_r) && (char_line == 4'hF);
    end
  end

  assign force_s = cur_hit_r;
`else
  logic unused_blink_s;
  assign unused_blink_s = ^BLINK_CYCLES;
  assign force_s        = 1'b0;
`endif

  font_rom u_font_rom (
    .pclk       (pclk),
    .rst        (rst),
    .addr       ({code_r[6:0], line_r}),
    .invert     (code_r[7]),
    .force_ones (force_s),
    .data       (char_pixels)
  );

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed self-checking bench for char_text_buffer; glyph rows are hand-derived
// from the 5x7 font (row bits placed at pixel bits 6:2, rows doubled from line 2).
module tb_char_text_buffer;

  logic       pclk;
  logic       rst;
  logic [7:0] char_xy;
  logic [3:0] char_line;
  logic [7:0] char_pixels;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_cmd;
  logic [7:0] wr_code;
  logic [7:0] cursor;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;
  int cnt;

  char_text_buffer #(
    .CLEAR_CHAR   (8'h20),
    .BLINK_CYCLES (32'd8)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .char_xy     (char_xy),
    .char_line   (char_line),
    .char_pixels (char_pixels),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_cmd      (wr_cmd),
    .wr_code     (wr_code),
    .cursor      (cursor),
    .busy        (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] code);
    wr_valid = 1'b1;
    wr_cmd   = cmd;
    wr_code  = code;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] xy, input logic [3:0] line,
                          input logic [7:0] exp);
    char_xy   = xy;
    char_line = line;
    step();
    step();
    check(tag, {8'h00, char_pixels}, {8'h00, exp});
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    char_xy   = 8'h00;
    char_line = 4'd0;
    wr_valid  = 1'b0;
    wr_cmd    = 2'b00;
    wr_code   = 8'h00;
    repeat (4) step();
    check("rst_busy", {15'd0, busy}, 16'd1);
    check("rst_ready", {15'd0, wr_ready}, 16'd0);
    check("rst_pixels", {8'h00, char_pixels}, 16'h0000);
    check("rst_cursor", {8'h00, cursor}, 16'h0000);

    rst = 1'b0;
    count_busy(cnt);
    check("init_clear_len", 16'(cnt), 16'd256);
    check("init_ready", {15'd0, wr_ready}, 16'd1);
    check("init_cursor", {8'h00, cursor}, 16'h0000);
    read_chk("clr_00_l5", 8'h00, 4'd5, 8'h00);
    read_chk("clr_ff_l15", 8'hFF, 4'd15, 8'h00);

    send(2'b00, 8'h41);
    check("put_cursor", {8'h00, cursor}, 16'h0010);
    char_xy   = 8'h10;
    char_line = 4'd5;
    step();
    step();
    char_xy = 8'h00;
    step();
    check("lat_1cyc", {8'h00, char_pixels}, 16'h0000);
    step();
    check("lat_2cyc_A_l5", {8'h00, char_pixels}, 16'h0044);

    send(2'b01, 8'hF3);
    check("setcur", {8'h00, cursor}, 16'h00F3);
    send(2'b00, 8'h42);
    check("put_wrap_col", {8'h00, cursor}, 16'h0004);
    read_chk("B_at_f3_l2", 8'hF3, 4'd2, 8'h78);
    send(2'b01, 8'h5F);
    send(2'b11, 8'h00);
    check("newline_wrap", {8'h00, cursor}, 16'h0000);

    send(2'b01, 8'h20);
    send(2'b00, 8'hC1);
    check("put_cursor_20", {8'h00, cursor}, 16'h0030);
    read_chk("inv_A_l3", 8'h20, 4'd3, 8'hC7);
    read_chk("inv_blank_l0", 8'h20, 4'd0, 8'hFF);

    // Same-cycle read and write of one cell returns the old code first.
    send(2'b01, 8'h50);
    char_xy   = 8'h50;
    char_line = 4'd5;
    wr_valid  = 1'b1;
    wr_cmd    = 2'b00;
    wr_code   = 8'h41;
    step();
    wr_valid = 1'b0;
    step();
    check("read_first_old", {8'h00, char_pixels}, 16'h0000);
    step();
    check("read_after_new", {8'h00, char_pixels}, 16'h0044);
    check("cursor_60", {8'h00, cursor}, 16'h0060);

    // CLEAR followed by a PUT held on wr_valid throughout the clear.
    wr_valid = 1'b1;
    wr_cmd   = 2'b10;
    step();
    wr_cmd  = 2'b00;
    wr_code = 8'h41;
    cnt = 0;
    while (wr_ready !== 1'b1 && cnt < 1000) begin
      cnt++;
      if (cnt == 100) check("clear_cursor_hold", {8'h00, cursor}, 16'h0060);
      step();
    end
    check("clear_ready_low", 16'(cnt), 16'd256);
    step();
    wr_valid = 1'b0;
    check("held_put_once", {8'h00, cursor}, 16'h0010);
    check("post_clear_busy", {15'd0, busy}, 16'd0);
    read_chk("held_put_A", 8'h00, 4'd5, 8'h44);
    read_chk("no_double_put", 8'h10, 4'd5, 8'h00);
    read_chk("cleared_50", 8'h50, 4'd5, 8'h00);

    // Reset at clear cycle 100 restarts the full clear.
    send(2'b10, 8'h00);
    repeat (99) step();
    check("mid_clear_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    step();
    step();
    check("midrst_busy", {15'd0, busy}, 16'd1);
    check("midrst_ready", {15'd0, wr_ready}, 16'd0);
    check("midrst_cursor", {8'h00, cursor}, 16'h0000);
    check("midrst_pixels", {8'h00, char_pixels}, 16'h0000);
    rst = 1'b0;
    count_busy(cnt);
    check("restart_clear_len", 16'(cnt), 16'd256);
    check("restart_ready", {15'd0, wr_ready}, 16'd1);
    read_chk("restart_cleared_00", 8'h00, 4'd5, 8'h00);

`ifdef CHAR_TEXT_CURSOR_EN
    send(2'b01, 8'h12);
    char_xy   = 8'h12;
    char_line = 4'd15;
    cnt = 0;
    while (char_pixels !== 8'hFF && cnt < 60) begin cnt++; step(); end
    while (char_pixels === 8'hFF && cnt < 60) begin cnt++; step(); end
    while (char_pixels !== 8'hFF && cnt < 60) begin cnt++; step(); end
    check("blink_sync_bound", {15'd0, cnt < 60}, 16'd1);
    for (int i = 0; i < 8; i++) begin
      check("blink_on_phase", {8'h00, char_pixels}, 16'h00FF);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      check("blink_off_phase", {8'h00, char_pixels}, 16'h0000);
      step();
    end
    check("blink_on_again", {8'h00, char_pixels}, 16'h00FF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
